// File: rtl/rand_arbiter_pkg.sv
// Shared types and width helpers for the rand_arbiter block.
// The fold state is only reachable when RAND_ARB_FOLD_EN is defined.
package rand_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROLL    = 3'd1,
    CAPTURE = 3'd2,
    FOLD    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Pointer width for an arbiter with n requesters (clog2, at least one bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Roll counter width: must hold ROLL_CYCLES-1.
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rand_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Shared with button/event arbitration elsewhere, so it carries no state.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Shares one `random` counter between N_REQ requesters: pick, roll, capture, grant.
// Define RAND_ARB_FOLD_EN to fold the captured value into [LO,HI] before the grant.
//
// Handshake: a requester holds its i_req bit high until its o_gnt bit pulses;
// o_valid pulses with o_gnt and o_value stays stable until the next capture.
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int N_REQ       = 2,
  parameter int ROLL_CYCLES = 3,
  parameter int LO          = 0,
  parameter int HI          = 127
) (
  input  logic             clk_rand_arbiter,
  input  logic             rst_rand_arbiter,
  input  logic [N_REQ-1:0] i_req,
  input  logic [WIDTH-1:0] i_random_binary,
  output logic             o_roll,
  output logic [N_REQ-1:0] o_gnt,
  output logic [WIDTH-1:0] o_value,
  output logic             o_valid,
  output logic             o_busy,
  output state_t           dbg_state
);

  localparam int PTR_W = ptr_w(N_REQ);
  localparam int CNT_W = cnt_w(ROLL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROLL_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

`ifdef RAND_ARB_FOLD_EN
  localparam logic [WIDTH:0]   RANGE = (WIDTH + 1)'(HI - LO + 1);
  localparam logic [WIDTH-1:0] LO_V  = WIDTH'(LO);
`endif

  if (N_REQ < 2 || N_REQ > 8 || ROLL_CYCLES < 1 || LO < 0 || LO > HI ||
      HI >= (1 << WIDTH)) begin : g_bad_params
    $error("rand_arbiter: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx_q, win_idx_d;
  logic [N_REQ-1:0]   win_oh_q, win_oh_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               roll_q, roll_d;

  logic [N_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (i_req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk_rand_arbiter or posedge rst_rand_arbiter) begin
    if (rst_rand_arbiter) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      value_q   <= '0;
      roll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      value_q   <= value_d;
      roll_q    <= roll_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    value_d   = value_q;
    roll_d    = roll_q;
    o_gnt     = '0;
    o_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        // Winner is frozen here; later changes on i_req cannot redirect the grant.
        if (pick_found) begin
          win_idx_d = pick_idx;
          win_oh_d  = pick_oh;
          cnt_d     = CNT_INIT;
          roll_d    = 1'b1;
          state_d   = ROLL;
        end
      end
      ROLL: begin
        if (cnt_q == '0) begin
          roll_d  = 1'b0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        value_d = i_random_binary;
`ifdef RAND_ARB_FOLD_EN
        state_d = FOLD;
`else
        state_d = DONE;
`endif
      end
`ifdef RAND_ARB_FOLD_EN
      FOLD: begin
        // Repeated subtraction: one RANGE per cycle, then shift up by LO.
        if ({1'b0, value_q} >= RANGE) begin
          value_d = value_q - RANGE[WIDTH-1:0];
        end else begin
          value_d = value_q + LO_V;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        o_gnt   = win_oh_q;
        o_valid = 1'b1;
        ptr_d   = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_roll    = roll_q;
  assign o_value   = value_q;
  assign o_busy    = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter with a stand-in `random` counter.
// Define RAND_ARB_FOLD_EN for both bench and RTL to exercise the folded range.
module tb_rand_arbiter;
  import rand_arbiter_pkg::*;

  localparam int W = 7;
  localparam int N = 2;
  localparam int R = 3;
`ifdef RAND_ARB_FOLD_EN
  localparam int LO = 10;
  localparam int HI = 40;
`else
  localparam int LO = 0;
  localparam int HI = 127;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_req = '0;
  logic [W-1:0] i_random_binary;
  logic         o_roll;
  logic [N-1:0] o_gnt;
  logic [W-1:0] o_value;
  logic         o_valid;
  logic         o_busy;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model state: round-robin pointer and generator count.
  int           m_ptr = 0;
  int           m_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] gen_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rand_arbiter #(
    .WIDTH       (W),
    .N_REQ       (N),
    .ROLL_CYCLES (R),
    .LO          (LO),
    .HI          (HI)
  ) dut (
    .clk_rand_arbiter (clk),
    .rst_rand_arbiter (rst),
    .i_req            (i_req),
    .i_random_binary  (i_random_binary),
    .o_roll           (o_roll),
    .o_gnt            (o_gnt),
    .o_value          (o_value),
    .o_valid          (o_valid),
    .o_busy           (o_busy),
    .dbg_state        (dbg_state)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Stand-in generator: advances by 2 per rolled cycle, output bit-reversed.
  always @(posedge clk or posedge rst) begin
    if (rst) gen_cnt <= '0;
    else if (o_roll) gen_cnt <= gen_cnt + W'(2);
  end
  assign i_random_binary = rev(gen_cnt);

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] pat);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[i]) if (pat[order[i]]) return order[i];
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    i_req = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_roll",  32'(o_roll),    32'(0));
    chk("rst_gnt",   32'(o_gnt),     32'(0));
    chk("rst_valid", 32'(o_valid),   32'(0));
    chk("rst_value", 32'(o_value),   32'(0));
    chk("rst_busy",  32'(o_busy),    32'(0));
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // mode 0: hold pattern; 1: drop all requests after cycle 1; 2: scramble at cycle 2.
  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle.
  task automatic txn(input logic [N-1:0] pat, input int mode);
    int           win;
    int           raw;
    int           exp_cyc;
    int           gnt_cyc;
    int           roll_n;
    bit           roll_bad;
    bit           busy_bad;
    logic [N-1:0] got_gnt;
    logic [N-1:0] exp_oh;
    logic [W-1:0] got_val;
    logic [W-1:0] expv;
    logic         got_valid;
    gnt_cyc   = 0;
    roll_n    = 0;
    roll_bad  = 1'b0;
    busy_bad  = 1'b0;
    got_gnt   = '0;
    got_val   = '0;
    got_valid = 1'b0;
    win       = pick(pat);
    exp_oh    = '0;
    exp_oh[win] = 1'b1;
    m_cnt = (m_cnt + 2 * R) % (1 << W);
    raw   = int'(rev(W'(m_cnt)));
`ifdef RAND_ARB_FOLD_EN
    expv    = W'(raw % (HI - LO + 1) + LO);
    exp_cyc = R + 2 + raw / (HI - LO + 1) + 1;
`else
    expv    = W'(raw);
    exp_cyc = R + 2;
`endif
    exp_q.push_back(expv);
    i_req = pat;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mode == 1 && c == 1) i_req = '0;
      if (mode == 2 && c == 2) i_req = N'($urandom_range(0, (1 << N) - 1));
      if (o_roll === 1'b1) roll_n++;
      if (o_roll !== ((c <= R) ? 1'b1 : 1'b0)) roll_bad = 1'b1;
      if (o_gnt !== '0) begin
        gnt_cyc   = c;
        got_gnt   = o_gnt;
        got_val   = o_value;
        got_valid = o_valid;
        break;
      end
      if (o_busy !== 1'b1) busy_bad = 1'b1;
    end
    chk("gnt_cycle",   32'(gnt_cyc),   32'(exp_cyc));
    chk("gnt_onehot",  32'(got_gnt),   32'(exp_oh));
    chk("valid_pulse", 32'(got_valid), 32'(1));
    chk("value",       32'(got_val),   32'(exp_q.pop_front()));
    chk("roll_count",  32'(roll_n),    32'(R));
    chk("roll_shape",  32'(roll_bad),  32'(0));
    chk("busy_during", 32'(busy_bad),  32'(0));
    m_ptr = (win + 1) % N;
    @(negedge clk);
    chk("busy_after",  32'(o_busy),  32'(0));
    chk("gnt_after",   32'(o_gnt),   32'(0));
    chk("valid_after", 32'(o_valid), 32'(0));
    chk("value_held",  32'(o_value), 32'(expv));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit quiet_bad;
    int gap;

    do_reset();
    txn(2'b01, 0);

    do_reset();
    txn(2'b11, 0);
    txn(2'b11, 0);
    txn(2'b11, 0);
    i_req = '0;

    txn(2'b10, 1);
    txn(2'b01, 0);

    // Reset during the second ROLL cycle: the pending grant must vanish.
    i_req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("roll_before_rst", 32'(o_roll), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_roll_async", 32'(o_roll), 32'(0));
    chk("rst_busy_async", 32'(o_busy), 32'(0));
    chk("rst_gnt_async",  32'(o_gnt),  32'(0));
    i_req = '0;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    quiet_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_gnt !== '0 || o_roll !== 1'b0 || o_busy !== 1'b0) quiet_bad = 1'b1;
    end
    chk("quiet_after_rst", 32'(quiet_bad), 32'(0));
    txn(2'b11, 0);

    for (int t = 0; t < 24; t++) begin
      gap   = $urandom_range(0, 2);
      i_req = '0;
      repeat (gap) begin
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 32'(0));
        chk("idle_roll", 32'(o_roll), 32'(0));
      end
      txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2));
    end

    i_req = '0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
